// File: rtl/data_mem_responder.sv
// Data-side memory responder: word RAM, console byte FIFO with status, and a free-running timer.
// Reads are combinational from the address; all state updates on the rising clock edge.
module data_mem_responder #(
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Alu_result,
  input  logic [31:0] writedata,
  input  logic        memwrite,
  output logic [31:0] read_data,
  output logic        cons_valid,
  output logic [7:0]  cons_data,
  input  logic        cons_ready
);

  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [29:0] WordConsData = 30'h0000_0400;
  localparam logic [29:0] WordConsStat = 30'h0000_0401;
  localparam logic [29:0] WordTimer    = 30'h0000_0402;

  logic [31:0]   ram_q  [RAM_WORDS];
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q, bus_error_q;
  logic [31:0]   timer_q;

  logic [29:0]   word_addr;
  logic [AW-1:0] ram_idx;
  logic          sel_ram, sel_cdata, sel_cstat, sel_timer, sel_unmapped;
  logic          empty, full, push, pop, push_ok;
  logic [31:0]   status;
  logic [1:0]    unused_addr_bits;

  // Word access only: the byte offset is ignored.
  assign unused_addr_bits = Alu_result[1:0];

  assign word_addr    = Alu_result[31:2];
  assign ram_idx      = Alu_result[AW+1:2];
  assign sel_ram      = (Alu_result[31:AW+2] == '0);
  assign sel_cdata    = (word_addr == WordConsData);
  assign sel_cstat    = (word_addr == WordConsStat);
  assign sel_timer    = (word_addr == WordTimer);
  assign sel_unmapped = !(sel_ram || sel_cdata || sel_cstat || sel_timer);

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = !empty && cons_ready;
  assign push    = memwrite && sel_cdata;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign push_ok = push && (!full || pop);

  assign cons_valid = !empty;
  assign cons_data  = empty ? 8'h00 : fifo_q[rd_ptr_q];

  assign status = {22'b0, bus_error_q, overflow_q, 6'(count_q), empty, full};

  always_comb begin
    read_data = 32'hDEAD_BEEF;
    if (sel_ram) begin
      read_data = ram_q[ram_idx];
    end else if (sel_cdata) begin
      read_data = {24'b0, cons_data};
    end else if (sel_cstat) begin
      read_data = status;
    end else if (sel_timer) begin
      read_data = timer_q;
    end
  end

  // Storage arrays carry no reset; the FIFO occupancy logic masks stale entries.
  always_ff @(posedge clk) begin
    if (memwrite && sel_ram) begin
      ram_q[ram_idx] <= writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_q[wr_ptr_q] <= writedata[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      bus_error_q <= 1'b0;
      timer_q     <= '0;
    end else begin
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      if (push && full && !pop) begin
        overflow_q <= 1'b1;
      end else if (memwrite && sel_cstat && writedata[8]) begin
        overflow_q <= 1'b0;
      end

      if (memwrite && sel_unmapped) begin
        bus_error_q <= 1'b1;
      end else if (memwrite && sel_cstat && writedata[9]) begin
        bus_error_q <= 1'b0;
      end

      if (memwrite && sel_timer) begin
        timer_q <= writedata;
      end else begin
        timer_q <= timer_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus randomized traffic against a
// queue-based reference model of the memory map.
module tb_data_mem_responder;

  localparam int RW = 64;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Alu_result, writedata, read_data;
  logic        memwrite, cons_valid, cons_ready;
  logic [7:0]  cons_data;

  always #5 clk = ~clk;

  data_mem_responder #(.RAM_WORDS(RW), .FIFO_DEPTH(FD)) dut (
    .clk        (clk),
    .reset      (reset),
    .Alu_result (Alu_result),
    .writedata  (writedata),
    .memwrite   (memwrite),
    .read_data  (read_data),
    .cons_valid (cons_valid),
    .cons_data  (cons_data),
    .cons_ready (cons_ready)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] ram_m [RW];
  bit          ram_v [RW];
  logic [7:0]  q [$];
  bit          ovf_m, berr_m;
  logic [31:0] tmr_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_head();
    return (q.size() != 0) ? {24'h0, q[0]} : 32'h0;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [31:0] wa;
    logic [31:0] st;
    wa = a & ~32'h3;
    st = 32'h0;
    st[0]   = (q.size() == FD);
    st[1]   = (q.size() == 0);
    st[7:2] = 6'(q.size());
    st[8]   = ovf_m;
    st[9]   = berr_m;
    if (a < RW * 4)          return ram_m[int'(a >> 2)];
    else if (wa == 32'h1000) return exp_head();
    else if (wa == 32'h1004) return st;
    else if (wa == 32'h1008) return tmr_m;
    else                     return 32'hDEAD_BEEF;
  endfunction

  task automatic model_edge(input logic [31:0] a, input logic [31:0] wd, input bit we,
                            input bit rdy);
    int          sz;
    bit          pop;
    bit          twr;
    logic [31:0] wa;
    sz  = q.size();
    pop = rdy && (sz > 0);
    twr = 1'b0;
    wa  = a & ~32'h3;
    if (pop) void'(q.pop_front());
    if (we) begin
      if (a < RW * 4) begin
        ram_m[int'(a >> 2)] = wd;
        ram_v[int'(a >> 2)] = 1'b1;
      end else if (wa == 32'h1000) begin
        if (sz < FD || pop) q.push_back(wd[7:0]);
        else ovf_m = 1'b1;
      end else if (wa == 32'h1004) begin
        if (wd[8]) ovf_m = 1'b0;
        if (wd[9]) berr_m = 1'b0;
      end else if (wa == 32'h1008) begin
        tmr_m = wd;
        twr   = 1'b1;
      end else begin
        berr_m = 1'b1;
      end
    end
    if (!twr) tmr_m = tmr_m + 32'd1;
  endtask

  // One clock cycle: drive at the falling edge, check combinational outputs, update model.
  task automatic step(input logic [31:0] a, input logic [31:0] wd, input bit we, input bit rdy);
    Alu_result = a;
    writedata  = wd;
    memwrite   = we;
    cons_ready = rdy;
    #1;
    if (!(a < RW * 4) || ram_v[int'(a >> 2)]) chk("read_data", read_data, exp_read(a));
    chk("cons_valid", 32'(cons_valid), 32'(q.size() != 0));
    chk("cons_data", 32'(cons_data), exp_head());
    @(posedge clk);
    model_edge(a, wd, we, rdy);
    @(negedge clk);
  endtask

  task automatic peek(input logic [31:0] a);
    Alu_result = a;
    memwrite   = 1'b0;
    #1;
  endtask

  task automatic idle();
    step(32'h1008, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    q.delete();
    ovf_m  = 1'b0;
    berr_m = 1'b0;
    tmr_m  = 32'h0;
  endtask

  initial begin
    reset      = 1'b1;
    Alu_result = 32'h1004;
    writedata  = 32'h0;
    memwrite   = 1'b0;
    cons_ready = 1'b0;
    for (int i = 0; i < RW; i++) ram_v[i] = 1'b0;
    model_reset();

    // Reset state and release
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cons_valid", 32'(cons_valid), 32'h0);
    chk("rst_cons_data", 32'(cons_data), 32'h0);
    chk("rst_stat", read_data, 32'h0000_0002);
    reset = 1'b0;
    peek(32'h1008);
    chk("rst_timer0", read_data, 32'h0);
    idle();
    peek(32'h1008);
    chk("rst_timer1", read_data, 32'h1);

    // RAM write/read-back
    step(32'h10, 32'h1234_5678, 1'b1, 1'b0);
    peek(32'h10);
    chk("ram_10", read_data, 32'h1234_5678);
    step(32'h14, 32'hA5A5_A5A5, 1'b1, 1'b0);
    peek(32'h14);
    chk("ram_14", read_data, 32'hA5A5_A5A5);
    for (int i = 0; i < RW; i++) step(32'(i * 4), $urandom, 1'b1, 1'b0);

    // FIFO fill, overflow and in-order drain
    for (int b = 8'h41; b <= 8'h45; b++) step(32'h1000, 32'(b), 1'b1, 1'b0);
    peek(32'h1004);
    chk("fill_stat", read_data, 32'h0000_0111);
    chk("fill_head", 32'(cons_data), 32'h41);
    for (int b = 8'h41; b <= 8'h44; b++) begin
      chk("drain_byte", 32'(cons_data), 32'(b));
      step(32'h1008, 32'h0, 1'b0, 1'b1);
    end
    chk("drain_empty", 32'(cons_valid), 32'h0);
    step(32'h1004, 32'h100, 1'b1, 1'b0);

    // Push into a full FIFO with a simultaneous pop
    for (int b = 8'h61; b <= 8'h64; b++) step(32'h1000, 32'(b), 1'b1, 1'b0);
    step(32'h1000, 32'h55, 1'b1, 1'b1);
    peek(32'h1004);
    chk("full_pop_stat", read_data, 32'h0000_0011);
    for (int b = 8'h62; b <= 8'h65; b++) begin
      chk("full_pop_byte", 32'(cons_data), (b == 8'h65) ? 32'h55 : 32'(b));
      step(32'h1008, 32'h0, 1'b0, 1'b1);
    end

    // Timer load and wrap
    step(32'h1008, 32'hFFFF_FFFE, 1'b1, 1'b0);
    peek(32'h1008);
    chk("tmr_load", read_data, 32'hFFFF_FFFE);
    idle();
    peek(32'h1008);
    chk("tmr_max", read_data, 32'hFFFF_FFFF);
    idle();
    peek(32'h1008);
    chk("tmr_wrap", read_data, 32'h0);

    // Unmapped access and bus_error clear
    peek(32'h2000);
    chk("unmapped_rd", read_data, 32'hDEAD_BEEF);
    step(32'h2000, 32'h1234, 1'b1, 1'b0);
    peek(32'h1004);
    chk("berr_set", 32'(read_data[9]), 32'h1);
    step(32'h1004, 32'h200, 1'b1, 1'b0);
    peek(32'h1004);
    chk("berr_clr", 32'(read_data[9]), 32'h0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a, wd;
      bit          we, rdy;
      int          sel;
      sel = int'($urandom_range(0, 9));
      wd  = $urandom;
      we  = ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 2) == 0);
      if (sel <= 3) begin
        a = 32'($urandom_range(0, RW - 1) * 4 + $urandom_range(0, 3));
      end else if (sel <= 5) begin
        a = 32'h1000 + 32'($urandom_range(0, 3));
      end else if (sel == 6) begin
        a = 32'h1004;
      end else if (sel == 7) begin
        a  = 32'h1008;
        we = ($urandom_range(0, 3) == 0);
      end else begin
        case ($urandom_range(0, 3))
          0:       a = 32'h2000;
          1:       a = 32'(RW * 4 + 4 * $urandom_range(0, 15));
          2:       a = 32'h100C;
          default: a = 32'hFFFF_FFF0;
        endcase
      end
      step(a, wd, we, rdy);
    end

    // Asynchronous reset with bytes queued
    step(32'h1004, 32'h300, 1'b1, 1'b0);
    for (int b = 1; b <= 3; b++) step(32'h1000, 32'(8'h70 + b), 1'b1, 1'b0);
    chk("pre_rst_valid", 32'(cons_valid), 32'h1);
    Alu_result = 32'h1004;
    memwrite   = 1'b0;
    cons_ready = 1'b1;
    reset      = 1'b1;
    #1;
    chk("midrst_valid", 32'(cons_valid), 32'h0);
    chk("midrst_stat", read_data, 32'h0000_0002);
    chk("midrst_data", 32'(cons_data), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle();
    peek(32'h1008);
    chk("post_rst_timer", read_data, 32'h1);
    for (int i = 0; i < 8; i++) step(32'(i * 4), 32'h0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter: RAM_WORDS, default 64, number of 32-bit RAM words; power of two.
REQ-002 Parameter: FIFO_DEPTH, default 4, console FIFO entries; power of two, at least 2.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: Alu_result  input  32  byte address of the core's data access.
REQ-006 Port: writedata  input  32  store data from the core.
REQ-007 Port: memwrite  input  1  store strobe, qualified by clk.
REQ-008 Port: read_data  output  32  load data returned to the core, combinational from address.
REQ-009 Port: cons_valid  output  1  console byte available; high while the FIFO is not empty.
REQ-010 Port: cons_data  output  8  console byte at the FIFO head.
REQ-011 Port: cons_ready  input  1  sink accepts the head byte when cons_valid and cons_ready are both high at a clock edge.

Function
REQ-012 Address decode SHALL use Alu_result[1:0]=don't-care (word access only) as follows:
- RAM: 0x0000_0000 up to RAM_WORDS*4-1
- CONS_DATA: 0x0000_1000
- CONS_STAT: 0x0000_1004
- TIMER: 0x0000_1008
- all other addresses: unmapped
REQ-013 RAM write: when memwrite=1, writedata is stored to word Alu_result[log2(RAM_WORDS)+1:2] at the edge.
REQ-014 RAM read: read_data returns the addressed word in the same cycle, including the value written at the previous edge.
REQ-015 CONS_DATA write pushes writedata[7:0] into the FIFO tail; CONS_DATA read returns {24'b0, head byte}, or 0 if empty, and does not pop.
REQ-016 CONS_STAT read returns:
- bit0 full
- bit1 empty
- bits[7:2] count, zero-extended
- bit8 overflow (sticky)
- bit9 bus_error (sticky)
- other bits 0
REQ-017 CONS_STAT write with writedata[8]=1 clears overflow, and with writedata[9]=1 clears bus_error; other bits are ignored.
REQ-018 Pop occurs when cons_valid and cons_ready are both high; head advances and count decrements.
REQ-019 Push into a non-full FIFO is always accepted.
REQ-020 Push while full with a pop in the same cycle is accepted: count is unchanged and no overflow is flagged.
REQ-021 Push while full without a pop is dropped, sets overflow, and leaves FIFO contents unchanged.
REQ-022 Push and pop in the same cycle on a non-full, non-empty FIFO leaves count unchanged.
REQ-023 FIFO read/write pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-024 TIMER is a 32-bit free-running counter incrementing by 1 every cycle and wrapping 0xFFFF_FFFF -> 0.
REQ-025 TIMER read returns the current value.
REQ-026 TIMER write loads writedata; the value is visible the next cycle, after which it resumes incrementing (the write wins over the increment in that cycle).
REQ-027 Unmapped read returns 0xDEAD_BEEF with no side effect.
REQ-028 Unmapped write changes no storage and sets bus_error.
REQ-029 When memwrite=0, no state changes except the timer increment and console pops.
REQ-030 cons_data SHALL be stable while cons_valid is high and no pop occurs.

Reset
REQ-031 While reset is high: FIFO empty (pointers 0, count 0), overflow=0, bus_error=0, TIMER=0, cons_valid=0, cons_data=0.
REQ-032 RAM contents are not reset; a bench SHALL write RAM before reading it.
REQ-033 Reset asserted mid-operation discards FIFO contents immediately; no pop is reported in that cycle.
REQ-034 Release of reset: TIMER reads 1 one cycle after the first edge with reset low.

Verification
REQ-035 RAM: write 0x1234_5678 at 0x0000_0010, then read 0x10 next cycle -> read_data=0x1234_5678; read 0x14 after writing 0xA5A5_A5A5 there -> 0xA5A5_A5A5.
REQ-036 FIFO fill: with cons_ready=0, push 0x41,0x42,0x43,0x44, then 0x45 -> CONS_STAT=0x0000_0111 (full, count 4, overflow); cons_data=0x41; drain with cons_ready=1 -> bytes 41,42,43,44 in order, then cons_valid=0.
REQ-037 Full-simultaneous: with the FIFO full and cons_ready=1, push 0x55 -> no overflow, count stays 4, 0x55 emerges last.
REQ-038 Timer: write 0xFFFF_FFFE to 0x1008 -> reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 on consecutive cycles.
REQ-039 Unmapped: read 0x0000_2000 -> 0xDEAD_BEEF; write 0x2000 -> CONS_STAT bit9=1; write 0x200 to 0x1004 -> bit9=0.
REQ-040 Reset mid-stream: assert reset with 3 bytes queued -> cons_valid=0 and CONS_STAT=0x0000_0002 immediately, with no clock edge required.
